// File: rtl/game_flow_pkg.sv
// Shared types for the game sequencer: FSM state encoding, BCD digit type, score ceiling.
package game_flow_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    HIT   = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/game_flow_ctrl_bcd_score4.sv
// 4-digit BCD score counter: synchronous clear, +1 with per-digit carry, saturates at 9999.
module bcd_score4
  import game_flow_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] score
);

  bcd_digit_t [3:0] dig, dig_n;

  always_comb begin
    logic carry;
    dig_n = dig;
    carry = inc && (dig != SCORE_MAX);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig[i] == 4'd9) begin
          dig_n[i] = 4'd0;
        end else begin
          dig_n[i] = dig[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (clr) dig_n = '0;
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) dig <= '0;
    else         dig <= dig_n;

  assign score = dig;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-synchronous game sequencer: serve/play/hit/over flow, lives and BCD score.
// Define GAME_PAUSE_EN to add a Select-driven PAUSE state.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int FRAME_LINE   = 480,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int HIT_FRAMES   = 90,
  parameter int SCORE_FRAMES = 30
)(
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  input  logic        Start,
  input  logic        Select,
  input  logic        collision,
  output logic        obj_resetN,
  output logic        move_en,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [15:0] score_bcd
);

  localparam int FMAX = (SERVE_FRAMES > HIT_FRAMES) ? SERVE_FRAMES : HIT_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int SW   = $clog2(SCORE_FRAMES + 1);

  state_t          st, st_n;
  logic [FW-1:0]   fcnt, fcnt_n;
  logic [SW-1:0]   scnt, scnt_n;
  logic [1:0]      lives_n;
  logic            tick_cond, tick_cond_d, frame_tick;
  logic            start_d, start_rise, start_pend;
  logic            hit_flag, hit, score_clr, score_inc;

  assign tick_cond = (pxl_x == 32'd0) && (pxl_y == 32'(FRAME_LINE));
  // A collision in the tick cycle itself still counts for that tick.
  assign hit       = hit_flag || (collision && st == PLAY);
  assign state     = st;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      tick_cond_d <= 1'b0;
      frame_tick  <= 1'b0;
      start_d     <= 1'b0;
      start_rise  <= 1'b0;
      start_pend  <= 1'b0;
      hit_flag    <= 1'b0;
    end else begin
      tick_cond_d <= tick_cond;
      frame_tick  <= tick_cond && !tick_cond_d;
      start_d     <= Start;
      start_rise  <= Start && !start_d;
      start_pend  <= start_rise || (start_pend && !frame_tick);
      hit_flag    <= !frame_tick && (hit_flag || (collision && st == PLAY));
    end

`ifdef GAME_PAUSE_EN
  logic select_d, select_rise, pause_pend;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      select_d    <= 1'b0;
      select_rise <= 1'b0;
      pause_pend  <= 1'b0;
    end else begin
      select_d    <= Select;
      select_rise <= Select && !select_d;
      pause_pend  <= select_rise || (pause_pend && !frame_tick);
    end
`else
  logic unused_select;
  assign unused_select = Select;
`endif

  always_comb begin
    st_n      = st;
    fcnt_n    = fcnt;
    scnt_n    = scnt;
    lives_n   = lives;
    score_clr = 1'b0;
    score_inc = 1'b0;
    if (frame_tick) begin
      case (st)
        IDLE, OVER:
          if (start_pend) begin
            st_n      = SERVE;
            fcnt_n    = '0;
            scnt_n    = '0;
            lives_n   = 2'(LIVES);
            score_clr = 1'b1;
          end
        SERVE:
          if (fcnt == FW'(SERVE_FRAMES - 1)) begin
            st_n   = PLAY;
            fcnt_n = '0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        PLAY:
          if (hit) begin
            st_n   = HIT;
            fcnt_n = '0;
            if (lives != 2'd0) lives_n = lives - 2'd1;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_pend) st_n = PAUSE;
`endif
          else if (scnt == SW'(SCORE_FRAMES - 1)) begin
            scnt_n    = '0;
            score_inc = 1'b1;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        HIT:
          if (fcnt == FW'(HIT_FRAMES - 1)) begin
            st_n   = (lives == 2'd0) ? OVER : SERVE;
            fcnt_n = '0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
`ifdef GAME_PAUSE_EN
        PAUSE:
          if (pause_pend) st_n = PLAY;
`endif
        default: st_n = IDLE;
      endcase
    end
  end

  // Object controls follow the state register by one cycle.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      st         <= IDLE;
      fcnt       <= '0;
      scnt       <= '0;
      lives      <= 2'(LIVES);
      obj_resetN <= 1'b0;
      move_en    <= 1'b0;
    end else begin
      st         <= st_n;
      fcnt       <= fcnt_n;
      scnt       <= scnt_n;
      lives      <= lives_n;
      obj_resetN <= (st == PLAY) || (st == HIT) || (st == PAUSE);
      move_en    <= (st == PLAY);
    end

  bcd_score4 u_score (
    .clk    (clk),
    .resetN (resetN),
    .clr    (score_clr),
    .inc    (score_inc),
    .score  (score_bcd)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl against a frame-level behavioural model.
module tb_game_flow_ctrl;

  localparam int FRAME_LINE = 480, LIVES = 3, SERVE_FRAMES = 2, HIT_FRAMES = 3, SCORE_FRAMES = 1;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_HIT = 3, S_OVER = 4, S_PAUSE = 5;

  logic        clk = 1'b0, resetN = 1'b1;
  logic [31:0] pxl_x = '0, pxl_y = '0;
  logic        Start = 1'b0, Select = 1'b0, collision = 1'b0;
  logic        obj_resetN, move_en;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [15:0] score_bcd;

  int cmps = 0, errs = 0;
  int m_state, m_lives, m_score, m_cnt, m_play;
  bit m_start, m_hit, m_pause;
  bit pre_on, pre_mv;
  logic [22:0] got, exp, early;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .FRAME_LINE(FRAME_LINE), .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES),
    .HIT_FRAMES(HIT_FRAMES), .SCORE_FRAMES(SCORE_FRAMES)
  ) dut (
    .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .Start(Start), .Select(Select), .collision(collision),
    .obj_resetN(obj_resetN), .move_en(move_en), .state(state),
    .lives(lives), .score_bcd(score_bcd)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [22:0] model_vec();
    bit on;
    on = (m_state == S_PLAY || m_state == S_HIT || m_state == S_PAUSE);
    return {3'(m_state), 2'(m_lives), to_bcd(m_score), on, m_state == S_PLAY};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_lives = LIVES; m_score = 0; m_cnt = 0; m_play = 0;
    m_start = 0; m_hit = 0; m_pause = 0;
  endtask

  // One frame's worth of game rules, applied at the frame boundary.
  task automatic model_tick();
    bit h, s, p;
    h = m_hit; s = m_start; p = m_pause;
    m_hit = 0; m_start = 0; m_pause = 0;
    case (m_state)
      S_IDLE, S_OVER:
        if (s) begin m_state = S_SERVE; m_lives = LIVES; m_score = 0; m_cnt = 0; m_play = 0; end
      S_SERVE: begin
        m_cnt++;
        if (m_cnt == SERVE_FRAMES) begin m_state = S_PLAY; m_cnt = 0; end
      end
      S_PLAY:
        if (h) begin m_state = S_HIT; m_cnt = 0; if (m_lives > 0) m_lives--; end
        else if (PAUSE_EN && p) m_state = S_PAUSE;
        else begin
          m_play++;
          if (m_play % SCORE_FRAMES == 0 && m_score < 9999) m_score++;
        end
      S_HIT: begin
        m_cnt++;
        if (m_cnt == HIT_FRAMES) begin m_state = (m_lives == 0) ? S_OVER : S_SERVE; m_cnt = 0; end
      end
      S_PAUSE: if (p) m_state = S_PLAY;
      default: ;
    endcase
  endtask

  // Events mid-frame, optional collision on the tick_cond / frame_tick cycles.
  task automatic frame(input bit st, input bit sel, input bit cm, input bit ctc, input bit cft);
    @(negedge clk); pxl_x = 32'd10; pxl_y = 32'd100; Start = st; Select = sel;
    if (st) m_start = 1;
    if (sel) m_pause = 1;
    @(negedge clk); Start = 0; Select = 0; collision = cm;
    if (cm && m_state == S_PLAY) m_hit = 1;
    @(negedge clk); collision = 0;
    @(negedge clk); pxl_x = 0; pxl_y = FRAME_LINE; collision = ctc;
    if (ctc && m_state == S_PLAY) m_hit = 1;
    @(negedge clk); pxl_x = 1; collision = cft;
    if (cft && m_state == S_PLAY) m_hit = 1;
    @(negedge clk); pxl_x = 2; collision = 0;
    pre_on = (m_state == S_PLAY || m_state == S_HIT || m_state == S_PAUSE);
    pre_mv = (m_state == S_PLAY);
    early  = {state, lives, score_bcd, obj_resetN, move_en};
    @(negedge clk);
    model_tick();
  endtask

  task automatic fast_frame();
    @(negedge clk); pxl_x = 0; pxl_y = FRAME_LINE;
    @(negedge clk); pxl_x = 1;
    @(negedge clk); pxl_x = 2;
    model_tick();
  endtask

  task automatic to_play();
    int n = 0;
    while (m_state != S_PLAY && n < 30) begin
      frame(m_state == S_IDLE || m_state == S_OVER, 0, 0, 0, 0);
      n++;
    end
    cmps++;
    if (state !== 3'(S_PLAY)) begin errs++; $display("FAIL to_play: state %0d want %0d", state, S_PLAY); end
  endtask

  task automatic test_reset();
    #2 resetN = 0;
    #1 model_reset();
    got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
    if (got !== exp) begin errs++; $display("FAIL reset_async: got %h want %h", got, exp); end
    repeat (3) @(negedge clk);
    resetN = 1;
    repeat (3) @(negedge clk);
    got = {state, lives, score_bcd, obj_resetN, move_en}; cmps++;
    if (got !== exp) begin errs++; $display("FAIL reset_release: got %h want %h", got, exp); end
  endtask

  task automatic test_start_serve();
    for (int i = 0; i < 3; i++) begin
      frame(i == 0, 0, 0, 0, 0);
      got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
      if (got !== exp) begin errs++; $display("FAIL start_serve[%0d]: got %h want %h", i, got, exp); end
    end
    cmps++;
    if (early[22:20] !== 3'(S_PLAY) || early[1] !== 1'b0)
      begin errs++; $display("FAIL play_entry_lag: state %0d obj %b want 2 / 0", early[22:20], early[1]); end
    cmps++;
    if (obj_resetN !== 1'b1 || move_en !== 1'b1 || lives !== 2'd3 || score_bcd !== 16'h0000)
      begin errs++; $display("FAIL play_entry: obj %b mv %b lives %0d score %h", obj_resetN, move_en, lives, score_bcd); end
  endtask

  task automatic test_play_score();
    for (int i = 0; i < 12; i++) begin
      frame(0, 0, 0, 0, 0);
      got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
      if (got !== exp) begin errs++; $display("FAIL play_score[%0d]: got %h want %h", i, got, exp); end
    end
    cmps++;
    if (score_bcd !== 16'h0012) begin errs++; $display("FAIL score12: got %h want 0012", score_bcd); end
    for (int n = 0; n < 10000 && m_score < 9998; n++) fast_frame();
    @(negedge clk);
    got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
    if (got !== exp) begin errs++; $display("FAIL score9998: got %h want %h", got, exp); end
    repeat (3) fast_frame();
    @(negedge clk);
    cmps++;
    if (score_bcd !== 16'h9999) begin errs++; $display("FAIL score_sat: got %h want 9999", score_bcd); end
  endtask

  task automatic test_hit();
    frame(0, 0, 1, 0, 0);
    cmps++;
    if (state !== 3'(S_HIT) || lives !== 2'd2 || move_en !== 1'b0)
      begin errs++; $display("FAIL hit_entry: state %0d lives %0d mv %b want 3/2/0", state, lives, move_en); end
    for (int i = 0; i < HIT_FRAMES + SERVE_FRAMES; i++) begin
      frame(0, 0, 0, 0, 0);
      got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
      if (got !== exp) begin errs++; $display("FAIL hit_recover[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_game_over();
    int n = 0;
    while (m_state != S_OVER && n < 60) begin
      frame(0, 0, m_state == S_PLAY, 0, 0);
      got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
      if (got !== exp) begin errs++; $display("FAIL to_over[%0d]: got %h want %h", n, got, exp); end
      n++;
    end
    repeat (3) frame(0, 0, 1, 1, 0);
    cmps++;
    if (state !== 3'(S_OVER) || lives !== 2'd0 || score_bcd !== to_bcd(m_score))
      begin errs++; $display("FAIL over_hold: state %0d lives %0d score %h", state, lives, score_bcd); end
    frame(1, 0, 0, 0, 0);
    cmps++;
    if (state !== 3'(S_SERVE) || lives !== 2'd3 || score_bcd !== 16'h0000)
      begin errs++; $display("FAIL restart: state %0d lives %0d score %h want 1/3/0000", state, lives, score_bcd); end
  endtask

  task automatic test_tick_collision();
    to_play();
    frame(1, 0, 0, 1, 0);
    got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
    if (got !== exp) begin errs++; $display("FAIL coll_tick_cond: got %h want %h", got, exp); end
    to_play();
    frame(0, 0, 0, 0, 1);
    got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
    if (got !== exp) begin errs++; $display("FAIL coll_tick_cycle: got %h want %h", got, exp); end
    to_play();
    for (int i = 0; i < 2; i++) begin
      frame(i == 0, 0, 0, 0, 0);
      got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
      if (got !== exp) begin errs++; $display("FAIL start_in_play[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_hit();
    to_play();
    frame(0, 0, 1, 0, 0);
    @(negedge clk); #2 resetN = 0;
    #1 model_reset();
    got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
    if (got !== exp) begin errs++; $display("FAIL reset_mid_hit: got %h want %h", got, exp); end
    @(negedge clk); resetN = 1;
    frame(0, 0, 0, 0, 0);
    got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
    if (got !== exp) begin errs++; $display("FAIL idle_after_reset: got %h want %h", got, exp); end
  endtask

  task automatic test_pause();
    to_play();
    for (int i = 0; i < 7; i++) begin
      frame(0, i == 0 || i == 6, i == 3, 0, 0);
      got = {state, lives, score_bcd, obj_resetN, move_en}; exp = model_vec(); cmps++;
      if (got !== exp) begin errs++; $display("FAIL pause[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      frame($urandom_range(5) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0,
            $urandom_range(9) == 0, $urandom_range(9) == 0);
      exp = model_vec();
      got = {state, lives, score_bcd, obj_resetN, move_en}; cmps++;
      if (got !== exp) begin errs++; $display("FAIL random[%0d]: got %h want %h", i, got, exp); end
      exp = {exp[22:2], pre_on, pre_mv}; cmps++;
      if (early !== exp) begin errs++; $display("FAIL random_lag[%0d]: got %h want %h", i, early, exp); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_serve();
    test_play_score();
    test_hit();
    test_game_over();
    test_tick_collision();
    test_reset_mid_hit();
    test_pause();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Frame-synchronous game sequencer for the arcade top level.
- Consumes the screen pixel coordinates, the Start/Select buttons and the object collision signal.
- Drives the object units' reset and move-enable, tracks lives, and keeps a 4-digit BCD score for the seven-segment displays.
- Sits between periphery_control and the object units; replaces the direct "~A" reset wiring.

Parameters:
FRAME_LINE, 480, pxl_y value at which the frame tick fires (first visible-blank line)
LIVES, 3, lives loaded at game start (1..3)
SERVE_FRAMES, 60, frames objects are held in reset before play
HIT_FRAMES, 90, freeze frames after a collision
SCORE_FRAMES, 30, play frames per +1 score

Ports:
clk  in  1  pixel clock (clk_25 domain)
resetN  in  1  asynchronous active-low reset
pxl_x  in  32  current pixel column
pxl_y  in  32  current pixel row
Start  in  1  Start button level, active-high
Select  in  1  Select button level, active-high
collision  in  1  per-pixel object overlap, active-high
obj_resetN  out  1  active-low reset to object units
move_en  out  1  object motion enable
state  out  3  current FSM state (encoding from package)
lives  out  2  remaining lives
score_bcd  out  16  4 BCD digits; [15:12] is the thousands digit

Behaviour:
- Reset: state=IDLE, obj_resetN=0, move_en=0, lives=LIVES, score_bcd=16'h0000, all counters and flags 0.
- Frame tick:
  - tick_cond = (pxl_x==0 && pxl_y==FRAME_LINE).
  - frame_tick is a registered 1-cycle pulse, high the cycle after tick_cond rises (tick_cond && !tick_cond_d).
  - Exactly one tick per frame.
- Start_rise / Select_rise: registered edge detect, 1-cycle pulses.
  - Start_rise sets start_pend. start_pend clears on the next frame_tick.
- Collision: hit_flag sets on collision while state==PLAY. It is evaluated and cleared at frame_tick; a collision in the tick cycle itself counts for that tick.
- All state transitions happen only on frame_tick. Outputs are registered and change the cycle after the transition.
- States and transitions:
  - IDLE: start_pend -> SERVE; lives=LIVES; score=0; fcnt=0.
  - SERVE: fcnt++ each tick; fcnt==SERVE_FRAMES-1 -> PLAY, fcnt=0.
  - PLAY: if hit_flag -> HIT, fcnt=0, lives-- (no other action that tick). Otherwise scnt++; when scnt==SCORE_FRAMES-1, scnt=0 and score +1 BCD.
  - HIT: fcnt++; when fcnt==HIT_FRAMES-1: lives==0 -> OVER, else -> SERVE, fcnt=0.
  - OVER: start_pend -> SERVE; lives=LIVES; score=0.
- Outputs per state:
  - obj_resetN = 0 in IDLE/SERVE/OVER; 1 in PLAY/HIT.
  - move_en = 1 only in PLAY.
- Score arithmetic: BCD with per-digit carry at 9. Saturates at 9999; never wraps.
- scnt persists across HIT/SERVE. It clears only on game start.
- Lives never underflow: the decrement happens only in PLAY with lives>=1.
- Simultaneous Start_rise in PLAY/HIT/SERVE: ignored, and start_pend clears at the next tick.
- resetN asserted mid-game returns everything to reset values asynchronously.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - Select_rise sets pause_pend.
  - At frame_tick, PLAY with pause_pend -> PAUSE: move_en=0, obj_resetN=1, counters held.
  - PAUSE with pause_pend -> PLAY.
  - hit_flag takes priority over pause in PLAY.
  - Collisions are not latched in PAUSE.
- Undefined: Select is ignored, the PAUSE state does not exist, and the state encoding is unchanged.

Decomposition:
- Package game_flow_pkg holds:
  - state enum (IDLE=0, SERVE=1, PLAY=2, HIT=3, OVER=4, PAUSE=5);
  - bcd_digit_t (logic [3:0]);
  - SCORE_MAX=16'h9999.
- Sub-module bcd_score4: synchronous 4-digit BCD counter with clear, inc and saturate. Same clk/resetN.

Test Plan (params SERVE_FRAMES=2, HIT_FRAMES=3, LIVES=3, SCORE_FRAMES=1, FRAME_LINE=480):
1. Reset, then Start pulse, then 2 ticks -> SERVE for 2 ticks then PLAY. obj_resetN rises one cycle after the PLAY entry, move_en=1, lives=3, score=0000.
2. PLAY for 12 ticks with no collision -> score_bcd=16'h0012. Preload 9998 and run 3 ticks -> 9999 held.
3. One collision pulse mid-frame in PLAY -> next tick: HIT, lives=2, move_en=0. After 3 ticks -> SERVE, then PLAY.
4. Three hits -> after the final HIT: OVER, lives=0, score frozen. Start -> SERVE with lives=3, score=0000.
5. Collision and tick_cond in the same cycle; Start in PLAY -> hit counted on that tick; Start ignored with no state change.
6. resetN low mid-HIT -> immediately IDLE, outputs at reset values. With GAME_PAUSE_EN: Select in PLAY -> PAUSE, score held for 5 ticks; Select again -> PLAY.
